// File: rtl/arbiter_rr_2ph_pkg.sv
// arb_2ph_pkg -- shared types and helpers for the 2-phase round-robin arbiter.
//   arb_state_e : FSM state encoding (IDLE, GRANT)
//   MAX_N       : largest supported channel count
//   ptr_w(n)    : width of a channel index for n channels (at least 1 bit)
package arb_2ph_pkg;

    localparam int MAX_N = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    function automatic int ptr_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/arbiter_rr_2ph_if.sv
// arb_2ph_if -- client/resource signal bundle of the 2-phase arbiter.
//   r     : per-channel request (transition signalled), client -> arbiter
//   a     : per-channel acknowledge, arbiter -> client
//   g     : per-channel grant, arbiter -> resource
//   d     : per-channel done, resource -> arbiter
//   owner : index of current/last granted channel
//   busy  : a grant is outstanding
// Modports: slave = arbiter side, master = environment (clients + resource).
interface arb_2ph_if
    import arb_2ph_pkg::*;
#(
    parameter int N = 4
) ();

    localparam int PTR_W = ptr_w(N);

    logic [N-1:0]     r;
    logic [N-1:0]     a;
    logic [N-1:0]     g;
    logic [N-1:0]     d;
    logic [PTR_W-1:0] owner;
    logic             busy;

    modport slave (
        input  r, d,
        output a, g, owner, busy
    );

    modport master (
        output r, d,
        input  a, g, owner, busy
    );

endinterface

// File: rtl/arbiter_rr_2ph_pick.sv
// arb_rr_pick -- combinational round-robin winner selection.
//   pend   : pending request vector
//   ptr    : first index to consider (highest priority this round)
//   valid  : at least one request pending
//   winner : first pending index at or after ptr, wrapping modulo N
// The pending vector is duplicated to 2N bits and the bits below ptr are
// masked off; the lowest set bit of that word, folded back modulo N, is the
// wrapped round-robin winner. The upper copy is never masked, so any pending
// request is always found.
module arb_rr_pick
    import arb_2ph_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]          pend,
    input  logic [ptr_w(N)-1:0]   ptr,
    output logic                  valid,
    output logic [ptr_w(N)-1:0]   winner
);

    localparam int PTR_W = ptr_w(N);

    logic [2*N-1:0] masked;
    logic           found;

    always_comb begin
        masked = {pend, pend} & ({(2*N){1'b1}} << ptr);
        valid  = |pend;
        winner = '0;
        found  = 1'b0;
        for (int i = 0; i < 2*N; i++) begin
            if (!found && masked[i]) begin
                found  = 1'b1;
                winner = (i >= N) ? PTR_W'(i - N) : PTR_W'(i);
            end
        end
    end

endmodule

// File: rtl/arbiter_rr_2ph.sv
// arbiter_rr_2ph -- N-channel 2-phase (transition signalled) arbiter sharing
// one 2-phase resource among N clients inside a clocked island.
//   clk  : clock, all state changes on rising edge
//   rstn : synchronous active-low reset
//   bus  : arb_2ph_if.slave (r/d in, a/g/owner/busy out)
// A channel is pending while r[i] != a[i]. In IDLE the winner gets g toggled
// and the FSM moves to GRANT; when the resource returns d[owner] == g[owner]
// the client is acked and the pointer advances past the owner.
// Build option: ARB_RR_2PH_FIXED_PRIO_EN removes the round-robin pointer and
// always grants the lowest pending index (channel 0 highest priority).
module arbiter_rr_2ph
    import arb_2ph_pkg::*;
#(
    parameter int N = 4
) (
    input  logic       clk,
    input  logic       rstn,
    arb_2ph_if.slave   bus
);

    localparam int PTR_W = ptr_w(N);

    arb_state_e       state;
    logic [N-1:0]     a_q;
    logic [N-1:0]     g_q;
    logic [PTR_W-1:0] owner_q;
    logic             busy_q;
    logic [PTR_W-1:0] rr_ptr;

    logic [N-1:0]     pend;
    logic             win_vld;
    logic [PTR_W-1:0] win;
    logic [PTR_W-1:0] ptr_nxt;

    assign pend    = bus.r ^ a_q;
    assign ptr_nxt = (owner_q == PTR_W'(N - 1)) ? '0 : owner_q + PTR_W'(1);

`ifdef ARB_RR_2PH_FIXED_PRIO_EN
    assign rr_ptr = '0;
`endif

    arb_rr_pick #(.N(N)) u_pick (
        .pend   (pend),
        .ptr    (rr_ptr),
        .valid  (win_vld),
        .winner (win)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= IDLE;
            a_q     <= '0;
            g_q     <= '0;
            owner_q <= '0;
            busy_q  <= 1'b0;
`ifndef ARB_RR_2PH_FIXED_PRIO_EN
            rr_ptr  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        g_q[win] <= ~g_q[win];
                        owner_q  <= win;
                        busy_q   <= 1'b1;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    // d on other channels is ignored; only the owner's
                    // done phase can close the transaction.
                    if (bus.d[owner_q] == g_q[owner_q]) begin
                        a_q[owner_q] <= ~a_q[owner_q];
                        busy_q       <= 1'b0;
`ifndef ARB_RR_2PH_FIXED_PRIO_EN
                        rr_ptr       <= ptr_nxt;
`endif
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ARB_RR_2PH_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr_nxt;
`endif

    assign bus.a     = a_q;
    assign bus.g     = g_q;
    assign bus.owner = owner_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_arbiter_rr_2ph.sv
module tb_arbiter_rr_2ph;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rstn;
    int   total = 0;
    int   bad   = 0;
    int   exp_seq [4];

    arb_2ph_if #(.N(N)) bus ();

    arbiter_rr_2ph #(.N(N)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Every-cycle checks: at most one outstanding grant, and the owner's
    // client must not toggle its request while its grant is outstanding.
    logic [N-1:0] r_prev = '0;
    logic         busy_prev = 1'b0;
    logic [1:0]   owner_prev = '0;

    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            chk("mutex", 32'($countones(bus.g ^ bus.d) <= 1), 32'd1);
            if (busy_prev && bus.busy && owner_prev == bus.owner)
                chk("proto", 32'(r_prev[bus.owner] != bus.r[bus.owner]), 32'd0);
        end
        r_prev     <= bus.r;
        busy_prev  <= bus.busy;
        owner_prev <= bus.owner;
    end

    initial begin
`ifdef ARB_RR_2PH_FIXED_PRIO_EN
        exp_seq = '{1, 1, 1, 1};
`else
        exp_seq = '{1, 3, 1, 3};
`endif
        // reset
        rstn = 1'b0; bus.r = '0; bus.d = '0;
        step(); step();
        chk("rst_a", bus.a, 0);
        chk("rst_g", bus.g, 0);
        chk("rst_owner", bus.owner, 0);
        chk("rst_busy", bus.busy, 0);
        rstn = 1'b1;
        step();
        chk("idle_g", bus.g, 0);

        // single channel 3
        bus.r = 4'b1000; step();
        chk("sgl_g", bus.g, 4'b1000);
        chk("sgl_busy", bus.busy, 1);
        chk("sgl_owner", bus.owner, 3);
        chk("sgl_a0", bus.a, 0);
        step();
        chk("sgl_hold", bus.g, 4'b1000);
        chk("sgl_hold_busy", bus.busy, 1);
        bus.d = 4'b1000; step();
        chk("sgl_a", bus.a, 4'b1000);
        chk("sgl_done_busy", bus.busy, 0);

        // wrap: ptr=0, ch1 busy while ch0 and ch2 request
        bus.r = 4'b1010; step();
        chk("wr_g1", bus.g, 4'b1010);
        chk("wr_own1", bus.owner, 1);
        bus.r = 4'b1111; step();
        chk("wr_hold", bus.g, 4'b1010);
        chk("wr_hold_busy", bus.busy, 1);
        bus.d = 4'b1010; step();
        chk("wr_a1", bus.a, 4'b1010);
        chk("wr_a1_busy", bus.busy, 0);
        step();
        chk("wr_own2", bus.owner, 2);
        chk("wr_g2", bus.g, 4'b1110);
        bus.d = 4'b1110; step();
        chk("wr_a2", bus.a, 4'b1110);
        step();
        chk("wr_own0", bus.owner, 0);
        chk("wr_g0", bus.g, 4'b1111);
        bus.d = 4'b1111; step();
        chk("wr_a0", bus.a, 4'b1111);
        chk("wr_a0_busy", bus.busy, 0);

        // withdrawal of ch2 while ch0 holds the grant
        bus.r = 4'b1110; step();
        chk("wd_g0", bus.g, 4'b1110);
        chk("wd_own0", bus.owner, 0);
        bus.r = 4'b1010; step();
        bus.r = 4'b1110; step();
        bus.d = 4'b1110; step();
        chk("wd_a0", bus.a, 4'b1110);
        step(); step();
        chk("wd_g", bus.g, 4'b1110);
        chk("wd_a", bus.a, 4'b1110);
        chk("wd_busy", bus.busy, 0);

        // reset while ch2 holds the grant
        bus.r = 4'b1010; step();
        chk("rm_g2", bus.g, 4'b1010);
        chk("rm_own2", bus.owner, 2);
        chk("rm_busy2", bus.busy, 1);
        rstn = 1'b0; bus.r = '0; bus.d = '0; step();
        chk("rm_a", bus.a, 0);
        chk("rm_g", bus.g, 0);
        chk("rm_busy", bus.busy, 0);
        chk("rm_owner", bus.owner, 0);
        rstn = 1'b1; step();
        bus.r = 4'b0010; step();
        chk("rm_g1", bus.g, 4'b0010);
        chk("rm_own1", bus.owner, 1);
        bus.d = 4'b0010; step();
        chk("rm_a1", bus.a, 4'b0010);

        // all four together from a fresh reset, done 3 cycles after grant
        rstn = 1'b0; bus.r = '0; bus.d = '0; step();
        rstn = 1'b1; step();
        bus.r = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("af_own", bus.owner, k);
            chk("af_g", bus.g, (1 << (k + 1)) - 1);
            chk("af_busy", bus.busy, 1);
            step(); step();
            bus.d[k] = 1'b1;
            step();
            chk("af_a", bus.a, (1 << (k + 1)) - 1);
            chk("af_idle", bus.busy, 0);
        end
        step(); step();
        chk("af_end_a", bus.a, 4'hf);
        chk("af_end_g", bus.g, 4'hf);

        // ch1 and ch3 re-request continuously, ptr=0
        bus.r = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("alt_own", bus.owner, exp_seq[k]);
            chk("alt_busy", bus.busy, 1);
            bus.d[exp_seq[k]] = ~bus.d[exp_seq[k]];
            step();
            chk("alt_ack_busy", bus.busy, 0);
            bus.r[exp_seq[k]] = ~bus.r[exp_seq[k]];
        end
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
